delay_scheduler: RTL and testbench

//  Shares one 4-bit loadable up-counter timer among N_REQ requesters, each asking for a programmable delay.

---
 rtl/delay_scheduler_pkg.sv | 14 +
 rtl/delay_scheduler_tick_timer.sv | 30 +++
 rtl/delay_scheduler.sv | 106 ++++++++++
 tb/tb_delay_scheduler.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/delay_scheduler_pkg.sv
// Shared definitions for the delay scheduler: FSM encoding and timer constants.
package delay_scheduler_pkg;

    localparam int              TMR_W  = 4;
    localparam logic [TMR_W-1:0] TC_VAL = 4'd15;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_COUNT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/delay_scheduler_tick_timer.sv
// tick_timer: 4-bit loadable up-counter shared by all requesters.
//   clk, rst_n : clock, async active-low reset (count -> 0)
//   load, val  : synchronous load of val (priority over en)
//   en         : increment by one, wrapping 15 -> 0
//   tc         : terminal count, combinational (count == 15)
module tick_timer
    import delay_scheduler_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [TMR_W-1:0] val,
    input  logic             en,
    output logic             tc
);

    logic [TMR_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (load)
            count <= val;
        else if (en)
            count <= count + TMR_W'(1);
    end

    assign tc = (count == TC_VAL);

endmodule

// File: rtl/delay_scheduler.sv
// delay_scheduler: round-robin arbiter handing one shared tick_timer to N_REQ
// requesters, each asking for a 4-bit delay. The winner's delay is latched at
// acceptance, the timer is preloaded with (15 - delay) and counted up to
// terminal count, then a one-cycle done pulse goes to the winner.
//   clk, rst_n : clock, async active-low reset
//   req        : level request per requester, held until done
//   delay      : 4-bit delay per requester, requester i at [4*i+3:4*i]
//   abort      : cancels the in-flight request (ignored in IDLE)
//   done       : one-hot completion pulse
//   busy       : high outside IDLE
//   gnt_valid  : a request is owned (LOAD, COUNT, DONE)
//   gnt_id     : owning requester, 0 when not valid
module delay_scheduler
    import delay_scheduler_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [4*N_REQ-1:0] delay,
    input  logic               abort,
    output logic [N_REQ-1:0]   done,
    output logic               busy,
    output logic               gnt_valid,
    output logic [ID_W-1:0]    gnt_id
);

    state_t           state, nxt;
    logic [ID_W-1:0]  rr_ptr, lat_id;
    logic [TMR_W-1:0] lat_dly;
    logic             win_found;
    logic [ID_W-1:0]  win_id;
    logic             tmr_load, tmr_en, tc;

    // First set request scanning upward from the pointer, wrapping mod N_REQ.
    function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                              input logic [ID_W-1:0]  p);
        logic [ID_W:0] res;
        int            j;
        res = '0;
        for (int i = 0; i < N_REQ; i++) begin
            j = (int'(p) + i) % N_REQ;
            if (!res[ID_W] && r[j])
                res = {1'b1, ID_W'(j)};
        end
        return res;
    endfunction

    assign {win_found, win_id} = rr_pick(req, rr_ptr);

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  if (win_found) nxt = S_LOAD;
            S_LOAD:  nxt = abort ? S_IDLE : S_COUNT;
            S_COUNT: if (abort)   nxt = S_IDLE;
                     else if (tc) nxt = S_DONE;
            S_DONE:  nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            rr_ptr  <= '0;
            lat_id  <= '0;
            lat_dly <= '0;
        end else begin
            state <= nxt;
            if (state == S_IDLE && win_found) begin
                lat_id  <= win_id;
                lat_dly <= delay[4*int'(win_id) +: 4];
            end
            // An aborted completion leaves the pointer where it was.
            if (state == S_DONE && !abort)
                rr_ptr <= (lat_id == ID_W'(N_REQ-1)) ? '0 : lat_id + ID_W'(1);
        end
    end

    // en drops at tc so the timer parks on 15 in DONE instead of wrapping;
    // abort freezes it as well.
    assign tmr_load = (state == S_LOAD)  && !abort;
    assign tmr_en   = (state == S_COUNT) && !tc && !abort;

    tick_timer u_tmr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (tmr_load),
        .val   (TC_VAL - lat_dly),
        .en    (tmr_en),
        .tc    (tc)
    );

    assign busy      = (state != S_IDLE);
    assign gnt_valid = busy;
    assign gnt_id    = gnt_valid ? lat_id : '0;

    // abort in the DONE cycle kills the pulse.
    for (genvar i = 0; i < N_REQ; i++) begin : g_done
        assign done[i] = (state == S_DONE) && !abort && (lat_id == ID_W'(i));
    end

endmodule

// File: tb/tb_delay_scheduler.sv
module tb_delay_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] delay;
    logic        abort;
    logic [3:0]  done;
    logic        busy, gnt_valid;
    logic [1:0]  gnt_id;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    delay_scheduler #(.N_REQ(4), .ID_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .delay     (delay),
        .abort     (abort),
        .done      (done),
        .busy      (busy),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] oh(input int id);
        return 4'(1 << id);
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; req = '0; abort = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    // Called in an IDLE cycle with req already driven so that id wins at the
    // next edge (E0). Walks LOAD, d+1 COUNT cycles, DONE, back to IDLE.
    task automatic serve(input int id, input int d, input bit drop);
        logic [3:0] save;
        step();
        chk("load_busy", busy, 1);
        chk("load_gv", gnt_valid, 1);
        chk("load_id", gnt_id, id);
        chk("load_done", done, 0);
        save = delay[4*id +: 4];
        delay[4*id +: 4] = ~save;   // must not affect the accepted request
        for (int k = 0; k <= d; k++) begin
            step();
            chk("cnt_tmr", dut.u_tmr.count, 15 - d + k);
            chk("cnt_done", done, 0);
            chk("cnt_id", gnt_id, id);
        end
        step();
        chk("done", done, oh(id));
        chk("done_tmr", dut.u_tmr.count, 15);
        delay[4*id +: 4] = save;
        if (drop) req[id] = 1'b0;
        step();
        chk("idle_busy", busy, 0);
        chk("idle_gv", gnt_valid, 0);
        chk("idle_id", gnt_id, 0);
        chk("idle_done", done, 0);
    endtask

    initial begin
        rst_n = 1'b0; req = '0; delay = '0; abort = 1'b0;
        #12;
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_gv", gnt_valid, 0);
        chk("rst_id", gnt_id, 0);
        chk("rst_tmr", dut.u_tmr.count, 0);
        do_reset();
        chk("idle_noreq", busy, 0);

        // single requester, d=5, then d=0 and d=15 boundaries
        req = 4'b0001; delay = 16'h0005;
        serve(0, 5, 1);
        step();
        chk("stay_idle", busy, 0);
        req = 4'b0001; delay = 16'h0000;
        serve(0, 0, 1);
        req = 4'b0001; delay = 16'h000F;
        serve(0, 15, 1);

        // all four held: 0,1,2,3,0 spaced d+4 = 6 cycles
        do_reset();
        delay = 16'h2222; req = 4'b1111;
        serve(0, 2, 0); serve(1, 2, 0); serve(2, 2, 0); serve(3, 2, 0); serve(0, 2, 0);
        req = '0;
        step();
        chk("rr4_idle", busy, 0);

        // two held requesters alternate
        do_reset();
        delay = 16'h0101; req = 4'b0101;
        serve(0, 1, 0); serve(2, 1, 0); serve(0, 1, 0); serve(2, 1, 0);
        req = '0;

        // abort in IDLE ignored, abort on the 4th COUNT cycle
        do_reset();
        req = 4'b0001; delay = 16'h0009; abort = 1'b1;
        step();
        abort = 1'b0;
        chk("ab_idle_ign", busy, 1);
        step(); step(); step(); step();
        chk("ab_tmr4", dut.u_tmr.count, 9);
        abort = 1'b1; req = '0;
        chk("ab_cnt_done", done, 0);
        step();
        abort = 1'b0;
        chk("ab_to_idle", busy, 0);
        chk("ab_tmr_hold", dut.u_tmr.count, 9);
        step();
        chk("ab_tmr_hold2", dut.u_tmr.count, 9);
        req = 4'b1001;                  // pointer still 0 -> 0 wins
        step();
        chk("ab_rr", gnt_id, 0);
        abort = 1'b1;                   // abort in LOAD
        step();
        abort = 1'b0; req = '0;
        chk("ab_load", busy, 0);

        // abort in DONE suppresses done and keeps pointer
        req = 4'b0010; delay = 16'h0010;
        step(); chk("abd_id", gnt_id, 1);
        step(); step(); step();
        abort = 1'b1;
        #1;
        chk("abd_done", done, 0);
        chk("abd_busy", busy, 1);
        step();
        abort = 1'b0;
        chk("abd_idle", busy, 0);
        req = 4'b1010;                  // pointer still 0 -> 1 wins
        step();
        chk("abd_rr", gnt_id, 1);

        // reset mid-COUNT
        do_reset();
        req = 4'b0001; delay = 16'h0009;
        step(); step(); step();
        #2 rst_n = 1'b0;
        #1;
        chk("mr_busy", busy, 0);
        chk("mr_gv", gnt_valid, 0);
        chk("mr_id", gnt_id, 0);
        chk("mr_done", done, 0);
        chk("mr_tmr", dut.u_tmr.count, 0);
        req = '0;
        step();
        rst_n = 1'b1;
        step(); step();
        chk("mr_idle", busy, 0);
        req = 4'b0001; delay = 16'h0003;
        serve(0, 3, 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
